// File: rtl/bytewr_pkg.sv
// Shared types and constants for the byte-enabled Avalon-MM write initiator.
// Misaligned splitting is compiled in only when BYTEWR_UNALIGNED_EN is defined.
package bytewr_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    FIN  = 2'd2
  } bytewr_state_e;

  // The only byteenable patterns the peripheral register decoders accept
  localparam logic [3:0] BE_W   = 4'b1111;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_B1  = 4'b0010;
  localparam logic [3:0] BE_B2  = 4'b0100;
  localparam logic [3:0] BE_B3  = 4'b1000;

  function automatic logic [3:0] be_lane(input logic [1:0] lane);
    logic [3:0] be;
    case (lane)
      2'd0:    be = BE_B0;
      2'd1:    be = BE_B1;
      2'd2:    be = BE_B2;
      2'd3:    be = BE_B3;
      default: be = BE_B0;
    endcase
    return be;
  endfunction

  // Rotate left by whole bytes so data byte k lands on lane (ofs+k) mod 4
  function automatic logic [31:0] lane_rotate(input logic [31:0] d, input logic [1:0] ofs);
    logic [31:0] r;
    case (ofs)
      2'd0:    r = d;
      2'd1:    r = {d[23:0], d[31:24]};
      2'd2:    r = {d[15:0], d[31:16]};
      2'd3:    r = {d[7:0],  d[31:8]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bytewr_chunk_sel.sv
// Picks the largest legal byteenable chunk at pointer lane ptr_lo with remain bytes left.
// With BYTEWR_UNALIGNED_EN undefined only aligned commands reach here, so the choice collapses.
module bytewr_chunk_sel
  import bytewr_pkg::*;
(
  input  logic [1:0] ptr_lo,
  input  logic [2:0] remain,
  output logic [3:0] byteenable,
  output logic [2:0] adv
);

  // Chunk decode from pointer lane and remaining byte count
  always_comb begin
    byteenable = BE_B0;
    adv        = 3'd1;
`ifdef BYTEWR_UNALIGNED_EN
    if ((ptr_lo == 2'd0) && (remain >= 3'd4)) begin
      byteenable = BE_W;
      adv        = 3'd4;
    end else if (!ptr_lo[0] && (remain >= 3'd2)) begin
      byteenable = ptr_lo[1] ? BE_HHI : BE_HLO;
      adv        = 3'd2;
    end else begin
      byteenable = be_lane(ptr_lo);
      adv        = 3'd1;
    end
`else
    case (remain)
      3'd4: begin
        byteenable = BE_W;
        adv        = 3'd4;
      end
      3'd2: begin
        byteenable = ptr_lo[1] ? BE_HHI : BE_HLO;
        adv        = 3'd2;
      end
      default: begin
        byteenable = be_lane(ptr_lo);
        adv        = 3'd1;
      end
    endcase
`endif
  end

endmodule

// File: rtl/avm_bytewrite_master.sv
// Avalon-MM write initiator: one byte/half/word command in, legal-byteenable beats out.
// Define BYTEWR_UNALIGNED_EN to split misaligned commands; otherwise they are rejected with err.
module avm_bytewrite_master
  import bytewr_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [31:0]       cmd_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic              done,
  output logic              err
);

  bytewr_state_e     state_r, state_nxt_s;
  logic [ADDR_W-1:0] ptr_r, ptr_nxt_s;
  logic [2:0]        rem_r, rem_nxt_s;
  logic [2:0]        adv_r;
  logic [2:0]        size_bytes_s;
  logic              illegal_s;
  logic              accept_s;
  logic              beat_ok_s;
  logic              load_s;
  logic              issue_s;
  logic              err_nxt_s;
  logic [3:0]        chunk_be_s;
  logic [2:0]        chunk_adv_s;

  // The chunk for the beat about to be issued is decoded from the next pointer
  bytewr_chunk_sel u_chunk_sel (
    .ptr_lo     (ptr_nxt_s[1:0]),
    .remain     (rem_nxt_s),
    .byteenable (chunk_be_s),
    .adv        (chunk_adv_s)
  );

  // Command size decode and legality check
  always_comb begin
    size_bytes_s = 3'd0;
    illegal_s    = 1'b0;
    case (cmd_size)
      SIZE_BYTE: size_bytes_s = 3'd1;
      SIZE_HALF: size_bytes_s = 3'd2;
      SIZE_WORD: size_bytes_s = 3'd4;
      default: begin
        size_bytes_s = 3'd0;
        illegal_s    = 1'b1;
      end
    endcase
`ifndef BYTEWR_UNALIGNED_EN
    if (((cmd_size == SIZE_HALF) && cmd_addr[0]) ||
        ((cmd_size == SIZE_WORD) && (cmd_addr[1:0] != 2'd0))) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = illegal_s;
    end
`endif
  end

  // Next-state, pointer and remaining-count logic
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    rem_nxt_s   = rem_r;
    load_s      = 1'b0;
    issue_s     = 1'b0;
    err_nxt_s   = 1'b0;
    accept_s    = cmd_ready & cmd_valid;
    beat_ok_s   = avm_write & ~avm_waitrequest;
    case (state_r)
      IDLE: begin
        if (accept_s && illegal_s) begin
          err_nxt_s = 1'b1;
        end else if (accept_s) begin
          state_nxt_s = BEAT;
          ptr_nxt_s   = cmd_addr;
          rem_nxt_s   = size_bytes_s;
          load_s      = 1'b1;
          issue_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BEAT: begin
        if (beat_ok_s) begin
          // Pointer wraps naturally modulo 2^ADDR_W
          ptr_nxt_s = ptr_r + {{(ADDR_W-3){1'b0}}, adv_r};
          rem_nxt_s = rem_r - adv_r;
          if (rem_nxt_s == 3'd0) begin
            state_nxt_s = FIN;
          end else begin
            issue_s = 1'b1;
          end
        end else begin
          state_nxt_s = BEAT;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, bookkeeping and registered bus/handshake outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      ptr_r          <= '0;
      rem_r          <= 3'd0;
      adv_r          <= 3'd0;
      cmd_ready      <= 1'b0;
      avm_address    <= '0;
      avm_write      <= 1'b0;
      avm_writedata  <= 32'd0;
      avm_byteenable <= 4'd0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      rem_r     <= rem_nxt_s;
      cmd_ready <= (state_nxt_s == IDLE);
      done      <= (state_nxt_s == FIN);
      err       <= err_nxt_s;
      if (load_s) begin
        avm_writedata <= lane_rotate(cmd_data, cmd_addr[1:0]);
      end
      if (issue_s) begin
        avm_write      <= 1'b1;
        avm_address    <= {ptr_nxt_s[ADDR_W-1:2], 2'b00};
        avm_byteenable <= chunk_be_s;
        adv_r          <= chunk_adv_s;
      end else if (beat_ok_s) begin
        avm_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avm_bytewrite_master.sv
// Scoreboard bench for avm_bytewrite_master; follows BYTEWR_UNALIGNED_EN like the RTL.
module tb_avm_bytewrite_master;

  localparam logic [1:0] K_BEAT = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } ev_t;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_data;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        done;
  logic        err;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  beats_done = 0;
  bit  rand_wait = 0;
  bit  stall_hold = 0;
  int  stall_left = 0;
  int  stall_at = -1;

  avm_bytewrite_master #(.ADDR_W(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_addr        (cmd_addr),
    .cmd_size        (cmd_size),
    .cmd_data        (cmd_data),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .done            (done),
    .err             (err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    ev_t e;
    e.kind = K_BEAT; e.addr = a; e.be = be; e.wd = wd;
    exp_q.push_back(e);
  endfunction

  function automatic void push_tag(input logic [1:0] k);
    ev_t e;
    e.kind = k; e.addr = 32'd0; e.be = 4'd0; e.wd = 32'd0;
    exp_q.push_back(e);
  endfunction

  // Reference: greedy largest naturally aligned chunk of 4/2/1 bytes fitting what is left
  function automatic void model_cmd(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int n, s, be_i;
    logic [31:0] p, wd;
    bit legal;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    legal = (n != 0);
`ifndef BYTEWR_UNALIGNED_EN
    if (n > 1 && (a % n) != 0) legal = 0;
`endif
    if (!legal) begin
      push_tag(K_ERR);
      return;
    end
    for (int j = 0; j < 4; j++) wd[8*j +: 8] = d[8*((j - int'(a[1:0])) & 3) +: 8];
    p = a;
    while (n > 0) begin
      s = 4;
      while (!(((p % s) == 0) && (s <= n))) s = s / 2;
      be_i = ((1 << s) - 1) << p[1:0];
      push_beat(p & 32'hFFFF_FFFC, be_i[3:0], wd);
      p = p + s;
      n = n - s;
    end
    push_tag(K_DONE);
  endfunction

  task automatic observe(input logic [1:0] kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 1'b0, {30'd0, kind}, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind == e.kind, {30'd0, kind}, {30'd0, e.kind});
      if (kind == K_BEAT && e.kind == K_BEAT) begin
        chk("beat_addr", avm_address == e.addr, avm_address, e.addr);
        chk("beat_be", avm_byteenable == e.be, {28'd0, avm_byteenable}, {28'd0, e.be});
        chk("beat_wd", avm_writedata == e.wd, avm_writedata, e.wd);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every observed beat, done and err
  initial begin
    bit          prev_stall;
    logic [68:0] prev_vec;
    prev_stall = 0;
    prev_vec = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_stable", {avm_write, avm_address, avm_byteenable, avm_writedata} == prev_vec,
              avm_address, prev_vec[67:36]);
        end
        if (avm_write && !avm_waitrequest) begin
          observe(K_BEAT);
          beats_done++;
        end
        if (done) observe(K_DONE);
        if (err) observe(K_ERR);
        prev_stall = avm_write && avm_waitrequest;
        prev_vec = {avm_write, avm_address, avm_byteenable, avm_writedata};
      end
    end
  end

  // Slave stall generator
  initial begin
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (stall_hold) begin
        avm_waitrequest = 1'b1;
      end else if (stall_left > 0 && avm_write && beats_done == stall_at) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else if (rand_wait) begin
        avm_waitrequest = ($urandom_range(0, 3) == 0);
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
  end

  task automatic drive_cmd(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int cnt;
    @(negedge clock);
    cnt = 0;
    while (!cmd_ready && cnt < 200) begin
      @(negedge clock);
      cnt++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", 1'b0, {31'd0, cmd_ready}, 32'd1);
    end else begin
      cmd_valid = 1'b1; cmd_addr = a; cmd_size = sz; cmd_data = d;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (!(exp_q.size() == 0 && cmd_ready) && cnt < 1000) begin
      @(negedge clock);
      cnt++;
    end
    chk("drain", exp_q.size() == 0 && cmd_ready, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_size = 2'd0; cmd_data = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", cmd_ready == 1'b0, {31'd0, cmd_ready}, 32'd0);
    chk("rst_write", avm_write == 1'b0, {31'd0, avm_write}, 32'd0);
    chk("rst_addr", avm_address == 32'd0, avm_address, 32'd0);
    chk("rst_wd", avm_writedata == 32'd0, avm_writedata, 32'd0);
    chk("rst_be", avm_byteenable == 4'd0, {28'd0, avm_byteenable}, 32'd0);
    chk("rst_done_err", {done, err} == 2'b00, {30'd0, done, err}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("ready_after_reset", cmd_ready == 1'b1, {31'd0, cmd_ready}, 32'd1);

    push_beat(32'h0000_0100, 4'b1111, 32'hAABB_CCDD); push_tag(K_DONE);
    drive_cmd(32'h0000_0100, 2'd2, 32'hAABB_CCDD);
    drain();

    push_beat(32'h0000_0100, 4'b0100, 32'h00EE_0000); push_tag(K_DONE);
    drive_cmd(32'h0000_0102, 2'd0, 32'h0000_00EE);
    drain();

    push_tag(K_ERR);
    drive_cmd(32'h0000_0200, 2'd3, 32'h1234_5678);
    @(negedge clock);
    chk("ill_err_pulse", err == 1'b1, {31'd0, err}, 32'd1);
    chk("ill_ready_back", cmd_ready == 1'b1, {31'd0, cmd_ready}, 32'd1);
    @(negedge clock);
    chk("ill_err_one_cycle", err == 1'b0, {31'd0, err}, 32'd0);
    drain();

`ifdef BYTEWR_UNALIGNED_EN
    push_beat(32'h0000_0100, 4'b0010, 32'hBBCC_DDAA);
    push_beat(32'h0000_0100, 4'b1100, 32'hBBCC_DDAA);
    push_beat(32'h0000_0104, 4'b0001, 32'hBBCC_DDAA);
    push_tag(K_DONE);
    drive_cmd(32'h0000_0101, 2'd2, 32'hAABB_CCDD);
    drain();

    stall_at = beats_done + 1; stall_left = 3;
    push_beat(32'h0000_0100, 4'b0010, 32'hBBCC_DDAA);
    push_beat(32'h0000_0100, 4'b1100, 32'hBBCC_DDAA);
    push_beat(32'h0000_0104, 4'b0001, 32'hBBCC_DDAA);
    push_tag(K_DONE);
    drive_cmd(32'h0000_0101, 2'd2, 32'hAABB_CCDD);
    drain();
    chk("stall_consumed", stall_left == 0, stall_left, 32'd0);

    push_beat(32'hFFFF_FFFC, 4'b1000, 32'h4411_2233);
    push_beat(32'h0000_0000, 4'b0011, 32'h4411_2233);
    push_beat(32'h0000_0000, 4'b0100, 32'h4411_2233);
    push_tag(K_DONE);
    drive_cmd(32'hFFFF_FFFF, 2'd2, 32'h1122_3344);
    drain();
`else
    push_tag(K_ERR);
    drive_cmd(32'h0000_0103, 2'd1, 32'h0000_BEEF);
    @(negedge clock);
    chk("mis_err_pulse", err == 1'b1, {31'd0, err}, 32'd1);
    chk("mis_no_write", avm_write == 1'b0, {31'd0, avm_write}, 32'd0);
    chk("mis_ready_back", cmd_ready == 1'b1, {31'd0, cmd_ready}, 32'd1);
    drain();

    stall_at = beats_done; stall_left = 3;
    push_beat(32'h0000_0300, 4'b1111, 32'hCAFE_F00D); push_tag(K_DONE);
    drive_cmd(32'h0000_0300, 2'd2, 32'hCAFE_F00D);
    drain();
    chk("stall_consumed", stall_left == 0, stall_left, 32'd0);
`endif

    stall_hold = 1;
    push_beat(32'h0000_0400, 4'b1111, 32'h0BAD_0BAD); push_tag(K_DONE);
    drive_cmd(32'h0000_0400, 2'd2, 32'h0BAD_0BAD);
    chk("mid_write_up", avm_write == 1'b1, {31'd0, avm_write}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_write", avm_write == 1'b0, {31'd0, avm_write}, 32'd0);
    chk("mid_rst_done", done == 1'b0, {31'd0, done}, 32'd0);
    chk("mid_rst_ready", cmd_ready == 1'b0, {31'd0, cmd_ready}, 32'd0);
    exp_q.delete();
    stall_hold = 0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_ready_after", cmd_ready == 1'b1, {31'd0, cmd_ready}, 32'd1);
    push_beat(32'h0000_0500, 4'b0011, 32'h0000_5A5A); push_tag(K_DONE);
    drive_cmd(32'h0000_0500, 2'd1, 32'h0000_5A5A);
    drain();

    rand_wait = 1;
    for (int i = 0; i < 150; i++) begin
      d  = $urandom;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = $urandom;
      model_cmd(a, sz, d);
      drive_cmd(a, sz, d);
    end
    drain();
    rand_wait = 0;
    repeat (3) @(negedge clock);
    chk("final_empty", exp_q.size() == 0, exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
